// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - divisor configuration handshake for baud_tick_gen
interface baud_tick_gen_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic              cfg_err;

    // Source offering a new divisor
    modport master (
        output cfg_valid,
        output cfg_int,
        output cfg_frac,
        input  cfg_ready,
        input  cfg_err
    );

    // Generator accepting the divisor
    modport slave (
        input  cfg_valid,
        input  cfg_int,
        input  cfg_frac,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - fractional-N baud generator with oversample, bit and square-wave outputs
module baud_tick_gen #(
    parameter int unsigned CLKF   = 50000000,
    parameter int unsigned BR     = 115200,
    parameter int unsigned OVS    = 16,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           resync,
    baud_tick_gen_if.slave cfg,
    output logic           rx_tick,
    output logic           tx_tick,
    output logic           bclk
);

    // Reset divisor: round(CLKF * 2^FRAC_W / (BR * OVS)), computed in 64 bits
    localparam longint unsigned NUM     = 64'(CLKF) << FRAC_W;
    localparam longint unsigned DEN_RAW = 64'(BR) * 64'(OVS);
    localparam longint unsigned DEN     = (DEN_RAW == 64'd0) ? 64'd1 : DEN_RAW;
    localparam longint unsigned D       = (NUM + DEN / 64'd2) / DEN;
    localparam longint unsigned D_INT   = D >> FRAC_W;

    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(D_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(D);

    localparam int unsigned       OS_W    = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0]   OS_HALF = OS_W'(OVS / 2 - 1);
    localparam logic [DIV_W:0]    P_ONE   = (DIV_W + 1)'(1);
    localparam logic [DIV_W-1:0]  INT_MIN = DIV_W'(2);

    generate
        if (BR == 0 || CLKF == 0 || OVS < 2 || (OVS % 2) != 0 ||
            D_INT < 64'd2 || D_INT >= (64'd1 << DIV_W)) begin : g_bad_params
            $fatal(1, "baud_tick_gen: invalid CLKF/BR/OVS/DIV_W combination");
        end
    endgenerate

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [OS_W-1:0]   os_cnt;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [DIV_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic              pending;

    logic [DIV_W:0]    period;
    logic [FRAC_W:0]   acc_sum;
    logic              clear_phase;
    logic              tick_ev;
    logic              tx_ev;
    logic              cfg_fire;
    logic              cfg_bad;
    logic              apply;

    // Current period stretches by one clock whenever the fraction accumulator overflowed
    assign period      = {1'b0, div_int} + {{DIV_W{1'b0}}, carry};
    assign acc_sum     = {1'b0, acc} + {1'b0, div_frac};
    // resync shares the en-low clear and wins over a coincident tick
    assign clear_phase = !en || resync;
    assign tick_ev     = !clear_phase && ({1'b0, cnt} == (period - P_ONE));
    assign tx_ev       = tick_ev && (os_cnt == OS_LAST);
    assign cfg_fire    = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_bad     = cfg.cfg_int < INT_MIN;
    // A pending divisor lands on a bit boundary while running, or at once while idle/resyncing
    assign apply       = pending && (clear_phase || tx_ev);

    // Clock counter, fractional accumulator and oversample position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            os_cnt <= '0;
        end else if (clear_phase) begin
            cnt    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            os_cnt <= '0;
        end else if (tick_ev) begin
            cnt            <= '0;
            {carry, acc}   <= acc_sum;
            os_cnt         <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Registered strobes and the square wave, high for the first half of each bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
            bclk    <= 1'b0;
        end else begin
            rx_tick <= tick_ev;
            tx_tick <= tx_ev;
            if (clear_phase) begin
                bclk <= 1'b0;
            end else if (tx_ev) begin
                bclk <= 1'b1;
            end else if (tick_ev && (os_cnt == OS_HALF)) begin
                bclk <= 1'b0;
            end
        end
    end

    // Config slot: reject tiny divisors, hold one pending divisor until its apply point
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_int   <= RST_INT;
            div_frac  <= RST_FRAC;
            pend_int  <= '0;
            pend_frac <= '0;
            pending   <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= 1'b0;
        end else begin
            cfg.cfg_err <= cfg_fire && cfg_bad;
            if (apply) begin
                div_int       <= pend_int;
                div_frac      <= pend_frac;
                pending       <= 1'b0;
                cfg.cfg_ready <= 1'b1;
            end else if (cfg_fire && !cfg_bad) begin
                pend_int      <= cfg.cfg_int;
                pend_frac     <= cfg.cfg_frac;
                pending       <= 1'b1;
                cfg.cfg_ready <= 1'b0;
            end
        end
    end

    a_cnt_in_period: assert property (@(posedge clk) disable iff (!reset_n)
        ({1'b0, cnt} < period));

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - scoreboard bench for baud_tick_gen
`timescale 1ns/1ps
module tb_baud_tick_gen;
    localparam int unsigned CLKF   = 16000000;
    localparam int unsigned BR     = 100000;
    localparam int unsigned OVS    = 16;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic en      = 1'b0;
    logic resync  = 1'b0;
    logic rx_tick;
    logic tx_tick;
    logic bclk;

    baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) cfg_bus ();

    baud_tick_gen #(
        .CLKF(CLKF), .BR(BR), .OVS(OVS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .resync(resync),
        .cfg(cfg_bus),
        .rx_tick(rx_tick),
        .tx_tick(tx_tick),
        .bclk(bclk)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int v;
    } ev_t;

    int   q_rx[$];
    int   q_tx[$];
    int   q_err[$];
    ev_t  q_rdy[$];
    ev_t  q_bclk[$];
    int   obs_rx[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    logic prev_rdy = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_bclk(input int c, input int v);
        ev_t e;
        e.c = c;
        e.v = v;
        q_bclk.push_back(e);
    endtask

    task automatic push_rdy(input int c, input int v);
        ev_t e;
        e.c = c;
        e.v = v;
        q_rdy.push_back(e);
    endtask

    task automatic drain_checks();
        chk("rx_missing", q_rx.size(), 0);
        chk("tx_missing", q_tx.size(), 0);
        chk("err_missing", q_err.size(), 0);
        chk("rdy_missing", q_rdy.size(), 0);
        chk("bclk_missing", q_bclk.size(), 0);
        q_rx.delete();
        q_tx.delete();
        q_err.delete();
        q_rdy.delete();
        q_bclk.delete();
    endtask

    // Monitor: every DUT strobe or ready change pops the scoreboard
    ev_t me;
    always @(negedge clk) begin
        if (mon_on) begin
            if (rx_tick === 1'b1) begin
                obs_rx.push_back(cyc);
                if (q_rx.size() == 0) chk("rx_unexpected", cyc, -1);
                else chk("rx_time", cyc, q_rx.pop_front());
            end
            if (tx_tick === 1'b1) begin
                if (q_tx.size() == 0) chk("tx_unexpected", cyc, -1);
                else chk("tx_time", cyc, q_tx.pop_front());
            end
            if (cfg_bus.cfg_err === 1'b1) begin
                if (q_err.size() == 0) chk("err_unexpected", cyc, -1);
                else chk("err_time", cyc, q_err.pop_front());
            end
            if (cfg_bus.cfg_ready !== prev_rdy) begin
                if (q_rdy.size() == 0) chk("rdy_unexpected", cyc, -1);
                else begin
                    me = q_rdy.pop_front();
                    chk("rdy_time", cyc, me.c);
                    chk("rdy_value", int'(cfg_bus.cfg_ready), me.v);
                end
            end
            while (q_bclk.size() > 0 && q_bclk[0].c <= cyc) begin
                me = q_bclk.pop_front();
                if (me.c < cyc) chk("bclk_sample_missed", cyc, me.c);
                else chk("bclk_level", int'(bclk), me.v);
            end
        end
        prev_rdy = cfg_bus.cfg_ready;
    end

    initial begin
        int r, s, b1, r2, e0, e;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_int   = '0;
        cfg_bus.cfg_frac  = '0;
        reset_n = 1'b0;
        en      = 1'b1;
        resync  = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_rx_tick", int'(rx_tick), 0);
        chk("reset_tx_tick", int'(tx_tick), 0);
        chk("reset_bclk", int'(bclk), 0);
        chk("reset_cfg_err", int'(cfg_bus.cfg_err), 0);
        chk("reset_cfg_ready", int'(cfg_bus.cfg_ready), 1);

        // Reset divisor 10.0: rx every 10, tx every 160, bclk high after tx
        r = cyc;
        reset_n = 1'b1;
        for (int k = 1; k <= 23; k++) q_rx.push_back(r + 10 * k);
        q_tx.push_back(r + 160);
        push_bclk(r + 159, 0);
        push_bclk(r + 160, 1);
        push_bclk(r + 234, 1);
        push_bclk(r + 235, 0);
        mon_on = 1'b1;

        // Rejected divisor: one-cycle error, ready untouched, spacing unchanged
        wait_cyc(r + 165);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_int   = 16'd1;
        cfg_bus.cfg_frac  = 8'h40;
        q_err.push_back(r + 166);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;

        // Resync at os_cnt=7, cnt=4
        s = r + 234;
        wait_cyc(s);
        resync = 1'b1;
        b1 = s + 1;
        for (int k = 1; k <= 16; k++) q_rx.push_back(b1 + 10 * k);
        q_tx.push_back(b1 + 160);
        push_bclk(b1, 0);
        push_bclk(b1 + 80, 0);
        push_bclk(b1 + 159, 0);
        push_bclk(b1 + 160, 1);
        @(negedge clk);
        resync = 1'b0;

        // Divisor 20.0 offered mid-bit: applied at the next tx_tick
        wait_cyc(b1 + 50);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_int   = 16'd20;
        cfg_bus.cfg_frac  = 8'd0;
        push_rdy(b1 + 51, 0);
        push_rdy(b1 + 160, 1);
        for (int j = 1; j <= 4; j++) q_rx.push_back(b1 + 160 + 20 * j);
        push_bclk(b1 + 249, 1);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;

        // Another divisor left pending, then reset mid-bit
        wait_cyc(b1 + 200);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_int   = 16'd30;
        cfg_bus.cfg_frac  = 8'd0;
        push_rdy(b1 + 201, 0);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;

        wait_cyc(b1 + 250);
        drain_checks();
        mon_on = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_rx_tick", int'(rx_tick), 0);
        chk("async_reset_tx_tick", int'(tx_tick), 0);
        chk("async_reset_bclk", int'(bclk), 0);
        chk("async_reset_cfg_err", int'(cfg_bus.cfg_err), 0);
        chk("async_reset_cfg_ready", int'(cfg_bus.cfg_ready), 1);
        repeat (3) @(negedge clk);

        // After release: reset divisor, pending config gone
        r2 = cyc;
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) q_rx.push_back(r2 + 10 * k);
        q_tx.push_back(r2 + 160);
        push_bclk(r2 + 160, 1);
        mon_on = 1'b1;

        // Fractional divisor 10.5 loaded while disabled
        e0 = r2 + 205;
        wait_cyc(e0);
        en = 1'b0;
        push_bclk(e0 + 1, 0);
        wait_cyc(e0 + 3);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_int   = 16'd10;
        cfg_bus.cfg_frac  = 8'd128;
        push_rdy(e0 + 4, 0);
        push_rdy(e0 + 5, 1);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;

        wait_cyc(e0 + 10);
        e = cyc;
        obs_rx.delete();
        for (int k = 1; k <= 33; k++) q_rx.push_back(e + (21 * k - 1) / 2);
        q_tx.push_back(e + 167);
        q_tx.push_back(e + 335);
        en = 1'b1;

        wait_cyc(e + 350);
        drain_checks();
        if (obs_rx.size() >= 33) chk("frac_span_32_ticks", obs_rx[32] - obs_rx[0], 336);
        else chk("frac_tick_count", obs_rx.size(), 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised fractional-N baud timing generator; successor to the fixed integer half-period divider.
- Produces an oversample strobe (`rx_tick`, OVS per bit) for the UART receiver, a 1x bit strobe (`tx_tick`) for the transmitter, and a compatible 50% square wave (`bclk`).
- The divisor is runtime-programmable through a valid/ready config port and takes effect on a bit boundary; phase can be realigned by the receiver on start-bit detection.

Parameters:
- CLKF, 50000000, input clock frequency in Hz.
- BR, 115200, reset baud rate in bits/s.
- OVS, 16, oversample ticks per bit; even, >=2.
- DIV_W, 16, width of integer divisor part.
- FRAC_W, 8, width of fractional divisor part.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  generator enable; low synchronously clears all phase state.
- resync  in  1  one-cycle pulse; restarts bit phase at 0.
- cfg_valid  in  1  new divisor offered.
- cfg_ready  out  1  config slot free.
- cfg_int  in  DIV_W  integer clocks per rx_tick.
- cfg_frac  in  FRAC_W  fractional clocks per rx_tick, in units of 2^-FRAC_W.
- cfg_err  out  1  one-cycle pulse; rejected config.
- rx_tick  out  1  one-cycle strobe, OVS per bit.
- tx_tick  out  1  one-cycle strobe, once per bit.
- bclk  out  1  square wave at the baud rate.

Behaviour:
- Elaboration: D = round(CLKF*2^FRAC_W/(BR*OVS)). $fatal if BR==0, CLKF==0, OVS odd or <2, D>>FRAC_W < 2, or D>>FRAC_W >= 2^DIV_W. Reset divisor {div_int, div_frac} = D.
- Reset (async, reset_n low):
  - cnt=0, acc=0, carry=0, os_cnt=0.
  - rx_tick=0, tx_tick=0, bclk=0, cfg_err=0, cfg_ready=1, pending=0.
  - div_int/div_frac = reset divisor.
- Period rule, per enabled cycle:
  - Current period P = div_int + carry.
  - If cnt == P-1: rx_tick=1 next cycle (registered output); cnt<=0; {carry, acc} <= acc + div_frac (FRAC_W+1-bit add; carry is the overflow bit).
  - Otherwise cnt<=cnt+1.
  - Long-run mean period = div_int + div_frac/2^FRAC_W.
- Oversample counter: on each rx_tick event os_cnt <= (os_cnt==OVS-1) ? 0 : os_cnt+1.
  - tx_tick asserts on the same cycle as the rx_tick where os_cnt was OVS-1.
  - bclk toggles on rx_tick events with os_cnt == OVS/2-1 or OVS-1. bclk is high for the first half-bit after tx_tick.
- Latency: after en rises, or after reset with en=1, the first rx_tick registers at the end of enabled cycle P and is visible the cycle after. The first tx_tick follows OVS rx_ticks.
- en low: cnt, acc, carry, os_cnt, bclk cleared to 0; no ticks; divisor registers retained.
- resync: same clear as en low, for one cycle, divisor retained. Counting resumes the following cycle.
- If resync and a tick event coincide, resync wins and the tick is suppressed.
- Config handshake:
  - Transfer when cfg_valid && cfg_ready.
  - If cfg_int < 2: no capture, cfg_err pulses the next cycle, cfg_ready stays 1.
  - Otherwise capture into the pending register; cfg_ready <= 0.
- Pending divisor apply point:
  - While en=1, apply on the cycle a tx_tick event occurs; the new P is used from the next period onward.
  - While en=0, or on resync, apply immediately with acc/carry cleared.
  - cfg_ready returns to 1 the cycle after apply.
  - Only one pending config at a time; cfg_valid while cfg_ready=0 is ignored (source holds).
- Mid-operation reset discards the pending config and restores the reset divisor.
- Arithmetic: cnt is DIV_W bits. cnt never exceeds 2^DIV_W-1 since div_int+carry <= 2^DIV_W-1+1 is prevented by the elaboration/cfg checks. Assert cnt < P in simulation.

Test Plan:
- CLKF=16000000, BR=100000, OVS=16, FRAC_W=8 (D=10.0), en=1 after reset -> rx_tick every 10 clk; tx_tick every 160 clk; bclk period 160, high 80 clk starting after the first tx_tick.
- Config cfg_int=10, cfg_frac=128 with en=0, then en=1 -> rx_tick spacings alternate 10,11,10,11…; 32 rx_ticks span exactly 336 clk.
- Config cfg_int=20, cfg_frac=0 mid-bit with en=1 -> cfg_ready drops the next cycle; spacing stays 10 until the next tx_tick, then 20; cfg_ready returns to 1 one cycle after apply.
- Config cfg_int=1 -> cfg_err single-cycle pulse; divisor unchanged; cfg_ready stays 1.
- Pulse resync at os_cnt=7, cnt=4 -> next rx_tick exactly 10 clk after resync deasserts; tx_tick 160 clk after; bclk low during the gap.
- Assert reset_n=0 asynchronously mid-bit with a config pending -> all outputs 0 immediately (cfg_ready=1); after release, spacing is 10 (reset divisor) and the pending config is lost.
